// File: rtl/cpu_pkg.sv
// ============================================================================
// Module   : cpu_pkg
// Purpose  : Shared decode and status constants for the multiply/divide path.
// Revision : 1.0
// ============================================================================
`default_nettype none

package cpu_pkg;

    localparam logic [4:0]  OPC_RTYPE   = 5'b00000;
    localparam logic [4:0]  ALUOP_MUL   = 5'b00110;
    localparam logic [4:0]  ALUOP_DIV   = 5'b00111;

    localparam logic [31:0] RSTATUS_MUL = 32'd4;
    localparam logic [31:0] RSTATUS_DIV = 32'd5;

    localparam logic [1:0]  ST_IDLE     = 2'd0;
    localparam logic [1:0]  ST_BUSY     = 2'd1;
    localparam logic [1:0]  ST_DONE     = 2'd2;

    function automatic logic [31:0] rstatus_code(input logic is_div);
        return is_div ? RSTATUS_DIV : RSTATUS_MUL;
    endfunction

endpackage

`default_nettype wire

// File: rtl/md_busy_counter.sv
// ============================================================================
// Module   : md_busy_counter
// Purpose  : Busy-cycle counter with clear/enable and a terminal-count flag.
// Revision : 1.0
// ============================================================================
`default_nettype none

module md_busy_counter #(
    parameter int               CNT_W    = 7,
    parameter logic [CNT_W-1:0] TC_VALUE = '1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clear,
    input  logic             i_enable,
    output logic [CNT_W-1:0] o_count,
    output logic             o_terminal
);

    localparam logic [CNT_W-1:0] c_one = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_count <= '0;
        end else if (i_enable) begin
            r_count <= r_count + c_one;
        end
    end

    assign o_count    = r_count;
    assign o_terminal = (r_count == TC_VALUE);

endmodule

`default_nettype wire

// File: rtl/multdiv_sequencer.sv
// ============================================================================
// Module   : multdiv_sequencer
// Purpose  : X-stage sequencer for the multi-cycle multiply/divide unit.
// Revision : 1.0
// ============================================================================
`default_nettype none

module multdiv_sequencer
    import cpu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CNT_W          = 7
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [4:0]  opcode_x,
    input  logic [4:0]  alu_op_x,
    input  logic        flush,
    input  logic [31:0] operand_a,
    input  logic [31:0] operand_b,
    input  logic [31:0] md_result,
    input  logic        md_exception,
    input  logic        md_ready,
    output logic [31:0] md_a,
    output logic [31:0] md_b,
    output logic        ctrl_mult,
    output logic        ctrl_div,
    output logic        stall,
    output logic        result_valid,
    output logic [31:0] result,
    output logic        exception,
    output logic [31:0] rstatus_val
);

    localparam logic [CNT_W-1:0] c_tc_value = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [1:0]       r_state;
    logic             r_op_is_div;
    logic [31:0]      r_md_a;
    logic [31:0]      r_md_b;
    logic             r_ctrl_mult;
    logic             r_ctrl_div;
    logic [31:0]      r_result;
    logic             r_exception;
    logic [31:0]      r_rstatus;

    logic             w_is_md;
    logic             w_accept;
    logic             w_busy;
    logic             w_ready_acc;
    logic             w_timeout;
    logic             w_stall;
    logic [CNT_W-1:0] w_count;
    logic             w_terminal;

    assign w_is_md  = (opcode_x == OPC_RTYPE) &&
                      ((alu_op_x == ALUOP_MUL) || (alu_op_x == ALUOP_DIV));
    assign w_accept = (r_state == ST_IDLE) && w_is_md && !flush;
    assign w_busy   = (r_state == ST_BUSY);

    // The pulse cycle (count 0) cannot complete, so a stale ready from a
    // previous op never retires the new one.
    assign w_ready_acc = w_busy && !flush && md_ready && (w_count != '0);
    assign w_timeout   = w_busy && !flush && w_terminal && !w_ready_acc;

    md_busy_counter #(
        .CNT_W    (CNT_W),
        .TC_VALUE (c_tc_value)
    ) u_busy_counter (
        .clk        (clock),
        .rst        (reset),
        .i_clear    (w_accept),
        .i_enable   (w_busy),
        .o_count    (w_count),
        .o_terminal (w_terminal)
    );

    always_comb begin
        w_stall = 1'b0;
        case (r_state)
            ST_IDLE: w_stall = w_is_md && !flush;
            ST_BUSY: w_stall = 1'b1;
            default: w_stall = 1'b0;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_op_is_div <= 1'b0;
            r_md_a      <= '0;
            r_md_b      <= '0;
            r_ctrl_mult <= 1'b0;
            r_ctrl_div  <= 1'b0;
            r_result    <= '0;
            r_exception <= 1'b0;
            r_rstatus   <= '0;
        end else begin
            r_ctrl_mult <= w_accept && !alu_op_x[0];
            r_ctrl_div  <= w_accept &&  alu_op_x[0];

            if (w_accept) begin
                r_md_a      <= operand_a;
                r_md_b      <= operand_b;
                r_op_is_div <= alu_op_x[0];
            end

            if (w_ready_acc) begin
                r_result    <= md_exception ? 32'd0 : md_result;
                r_exception <= md_exception;
                r_rstatus   <= md_exception ? rstatus_code(r_op_is_div) : 32'd0;
            end else if (w_timeout) begin
                r_result    <= 32'd0;
                r_exception <= 1'b1;
                r_rstatus   <= rstatus_code(r_op_is_div);
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_state <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (flush) begin
                        r_state <= ST_IDLE;
                    end else if (w_ready_acc || w_timeout) begin
                        r_state <= ST_DONE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign md_a         = r_md_a;
    assign md_b         = r_md_b;
    assign ctrl_mult    = r_ctrl_mult;
    assign ctrl_div     = r_ctrl_div;
    assign stall        = w_stall;
    assign result_valid = (r_state == ST_DONE);
    assign result       = r_result;
    assign exception    = r_exception;
    assign rstatus_val  = r_rstatus;

endmodule

`default_nettype wire

// File: doc/multdiv_sequencer.md
Name: multdiv_sequencer

Overview:
- Sequences the multi-cycle multiply/divide unit for the 5-stage pipeline.
- Sits in the X stage beside the main ALU:
  - detects R-type mul/div from the decoded opcode and ALU op,
  - latches the operands,
  - issues a one-cycle start pulse to the multdiv unit,
  - stalls F/D/X until the result is ready,
  - presents the result, or an rstatus exception code, for one cycle.

Parameters:
- TIMEOUT_CYCLES, 64, number of BUSY cycles before the op is forcibly ended with an exception.
- CNT_W, 7, width of the busy-cycle counter; must hold TIMEOUT_CYCLES.

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high
- opcode_x  in  5  opcode of the instruction in X
- alu_op_x  in  5  ALU op field of the instruction in X
- flush  in  1  kill the instruction in X (taken branch/jump resolved this cycle)
- operand_a  in  32  rs value, post-bypass
- operand_b  in  32  rt value, post-bypass
- md_result  in  32  multdiv result
- md_exception  in  1  multdiv exception (overflow / divide-by-zero)
- md_ready  in  1  multdiv result ready
- md_a  out  32  latched operand A to multdiv
- md_b  out  32  latched operand B to multdiv
- ctrl_mult  out  1  multiply start pulse
- ctrl_div  out  1  divide start pulse
- stall  out  1  freeze PC, F/D and D/X latches; insert bubble into X/M
- result_valid  out  1  result available this cycle
- result  out  32  product/quotient, or 0 on exception
- exception  out  1  write rstatus ($r30) instead of rd
- rstatus_val  out  32  4 for mul exception, 5 for div exception, else 0

Behaviour:
- is_md = (opcode_x == 5'b00000) & (alu_op_x == 5'b00110 mul or 5'b00111 div).
- States:
  - IDLE → BUSY when is_md & ~flush.
  - BUSY → DONE on an accepted md_ready or on timeout.
  - BUSY → IDLE on flush.
  - DONE → IDLE unconditionally.
- Reset (any state, mid-op included): go to IDLE; all outputs 0; counter 0; op_is_div 0. Multdiv state is abandoned; a late md_ready is ignored because the FSM is in IDLE.
- IDLE:
  - stall = is_md & ~flush (combinational).
  - On acceptance, register md_a ← operand_a, md_b ← operand_b, op_is_div ← alu_op_x[0], counter ← 0.
- BUSY, first cycle (counter == 0):
  - ctrl_mult = ~op_is_div; ctrl_div = op_is_div. Registered outputs, exactly one cycle wide.
  - md_ready is ignored in this cycle.
- BUSY, every cycle:
  - stall = 1; counter increments.
  - md_ready with counter ≥ 1 → DONE; capture result ← md_result, exception ← md_exception.
  - counter == TIMEOUT_CYCLES−1 with no md_ready → DONE with exception = 1, result = 0.
  - md_ready and timeout in the same cycle: md_ready wins.
- DONE: stall = 0; result_valid = 1 for exactly one cycle.
  - The instruction in X advances to X/M at the end of this cycle.
  - is_md is not evaluated in DONE, so the same instruction cannot retrigger.
- Exception handling:
  - rstatus_val = 4 (mul) or 5 (div) when exception = 1, else 0.
  - On exception, result is forced to 0.
  - result, exception and rstatus_val hold their values until the next DONE. Consumers qualify them with result_valid.
- Flush:
  - In IDLE, flush suppresses acceptance; stall = 0.
  - In BUSY, flush → IDLE next cycle with no result_valid; stall deasserts the cycle after flush.
  - flush in DONE has no effect on the state sequence.
- md_a and md_b are stable from the pulse cycle through DONE.
- Minimum latency from acceptance to result_valid is 3 cycles: accept, pulse, ready.

Decomposition:
- Shared cpu_pkg constants:
  - OPC_RTYPE = 5'b00000, ALUOP_MUL = 5'b00110, ALUOP_DIV = 5'b00111
  - RSTATUS_MUL = 4, RSTATUS_DIV = 5
  - FSM state encoding: IDLE = 0, BUSY = 1, DONE = 2, 2-bit field.
- One natural sub-module: md_busy_counter. It is a CNT_W-bit synchronous counter with clear and enable, and it outputs a terminal-count flag.

Test Plan:
- mul, operand_a = 7, operand_b = 6, md_ready after 3 BUSY cycles, md_result = 42 → ctrl_mult exactly 1 cycle; stall high 4 cycles; result_valid 1 cycle with result = 42, exception = 0.
- div, operand_a = 100, operand_b = 0, md_exception = 1 with md_ready → exception = 1, rstatus_val = 5, result = 0, ctrl_div pulsed once.
- mul, md_ready never asserted → DONE after 64 BUSY cycles with exception = 1, rstatus_val = 4; stall drops in the DONE cycle.
- Flush at BUSY cycle 5 → FSM back to IDLE; no result_valid; a later stray md_ready produces no output.
- Reset asserted at BUSY cycle 10 → all outputs 0 next cycle; new div 20/4 then completes with result = 5.
- Back-to-back mul then div in consecutive instructions → two separate pulses; no retrigger in DONE; two result_valid pulses in order.
